// File: rtl/autoconfig_pkg.sv
// Shared constants for the Zorro II autoconfig sequencer.
// Holds state codes, register offsets, the config window and board ROM images.
package autoconfig_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [5:0] ZA_BASE_HI = 6'h24;
    localparam logic [5:0] ZA_BASE_LO = 6'h25;
    localparam logic [5:0] ZA_SHUTUP  = 6'h26;

    localparam logic [15:0] ZWINDOW = 16'h00E8;

    // Board 0 is the RAM image; higher boards share its layout with other ids.
    function automatic logic [NIB_W-1:0] rom_nibble(
        input logic [1:0] board,
        input logic [5:0] za
    );
        logic [NIB_W-1:0] n;
        n = 4'hF;
        case (za)
            6'h00: n = (board == 2'd0) ? 4'hA : 4'hD;
            6'h01: n = (board == 2'd0) ? 4'h2 : 4'h1;
            6'h03: n = 4'hC;
            6'h04: n = 4'h4;
            6'h08: n = 4'hE;
            6'h09: n = 4'hC;
            6'h0A: n = 4'h2;
            6'h0B: n = 4'h7;
            6'h11: n = 4'hE;
            6'h12: n = 4'hB;
            6'h13: n = 4'h5 + {2'b00, board};
            default: n = 4'hF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/autoconfig_rom.sv
// Autoconfig ROM lookup: board index and zaddr to a data nibble.
// Purely combinational; the sequencer registers the result.
module autoconfig_rom
    import autoconfig_pkg::*;
(
    input  logic [1:0]       board,
    input  logic [5:0]       zaddr,
    output logic [NIB_W-1:0] nibble
);

    assign nibble = rom_nibble(board, zaddr);

endmodule

// File: rtl/autoconfig_sequencer.sv
// Zorro II autoconfig sequencer: walks the board chain through the $E80000
// window, latches assigned bases and times the cycle acknowledge.
module autoconfig_sequencer
    import autoconfig_pkg::*;
#(
    parameter int NUM_BOARDS = 2,
    parameter int ACK_WAIT   = 2,
    parameter int ROM_BITS   = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    AS20,
    input  logic                    DS20,
    input  logic                    RW20,
    input  logic [31:0]             A,
    input  logic [ROM_BITS-1:0]     DIN,
    output logic [ROM_BITS-1:0]     DOUT,
    output logic                    DOE,
    output logic                    ACK,
    output logic                    ACCESS,
    output logic [4*NUM_BOARDS-1:0] BASE,
    output logic [NUM_BOARDS-1:0]   CONFIGURED,
    output logic [NUM_BOARDS-1:0]   SHUTUP,
    output logic                    CFG_DONE
);

    // ACK_WAIT of zero skips WAIT entirely so ACK lands 3 clocks after strobes.
    localparam bit         SKIP_WAIT = (ACK_WAIT == 0);
    localparam logic [2:0] WAIT_LOAD = SKIP_WAIT ? 3'd0 : 3'(ACK_WAIT - 1);

    logic       as_s1, as_s, ds_s1, ds_s;
    logic [1:0] state;
    logic [2:0] count;
    logic [1:0] cur, nxt_cur;
    logic       rd;
    logic [5:0] za;
    logic [3:0] stage;
    logic [3:0] rom_nib;
    logic       hit, start;
    logic       unused_ok;

    assign unused_ok = ^{A[15:7], A[0], stage};

    assign CFG_DONE = &(CONFIGURED | SHUTUP);
    assign hit      = (A[31:16] == ZWINDOW) && !CFG_DONE;
    assign ACCESS   = !hit;
    assign start    = !as_s && !ds_s && hit;
    assign ACK      = (state == ST_ACK) || (state == ST_HOLD);
    assign DOE      = rd && (state != ST_IDLE);

    always_comb begin
        nxt_cur = 2'd0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (!(CONFIGURED[i] | SHUTUP[i])) nxt_cur = 2'(i);
        end
    end

    autoconfig_rom u_rom (
        .board  (cur),
        .zaddr  (A[6:1]),
        .nibble (rom_nib)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            as_s1 <= 1'b1;
            as_s  <= 1'b1;
            ds_s1 <= 1'b1;
            ds_s  <= 1'b1;
        end else begin
            as_s1 <= AS20;
            as_s  <= as_s1;
            ds_s1 <= DS20;
            ds_s  <= ds_s1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            count      <= 3'd0;
            cur        <= 2'd0;
            rd         <= 1'b0;
            za         <= 6'd0;
            stage      <= 4'd0;
            DOUT       <= 4'hF;
            BASE       <= '0;
            CONFIGURED <= '0;
            SHUTUP     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cur <= nxt_cur;
                    if (start) begin
                        rd    <= RW20;
                        za    <= A[6:1];
                        count <= WAIT_LOAD;
                        state <= SKIP_WAIT ? ST_ACK : ST_WAIT;
                        if (RW20) DOUT <= rom_nib;
                    end
                end
                ST_WAIT: begin
                    if (as_s) state <= ST_IDLE;
                    else if (count == 3'd0) state <= ST_ACK;
                    else count <= count - 3'd1;
                end
                ST_ACK: begin
                    state <= ST_HOLD;
                    if (!rd) begin
                        for (int i = 0; i < NUM_BOARDS; i++) begin
                            if (cur == 2'(i)) begin
                                if (za == ZA_BASE_HI) begin
                                    BASE[4*i +: 4] <= DIN;
                                    CONFIGURED[i]  <= 1'b1;
                                end
                                if (za == ZA_SHUTUP) SHUTUP[i] <= 1'b1;
                            end
                        end
                        if (za == ZA_BASE_LO) stage <= DIN;
                    end
                end
                ST_HOLD: begin
                    if (as_s) begin
                        state <= ST_IDLE;
                        rd    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_sequencer.sv
// Randomised bench for autoconfig_sequencer against a table-driven
// model of the board chain (flags, bases and ROM images per board).
module tb_autoconfig_sequencer;

    localparam int NB = 2;
    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          AS20 = 1'b1;
    logic          DS20 = 1'b1;
    logic          RW20 = 1'b1;
    logic [31:0]   A = 32'd0;
    logic [3:0]    DIN = 4'd0;
    logic [3:0]    DOUT;
    logic          DOE, ACK, ACCESS, CFG_DONE;
    logic [4*NB-1:0] BASE;
    logic [NB-1:0] CONFIGURED, SHUTUP;

    int total = 0;
    int bad = 0;

    logic [3:0] rom_m [4][64];
    bit         m_cfg [NB];
    bit         m_shut [NB];
    logic [3:0] m_base [NB];

    autoconfig_sequencer #(.NUM_BOARDS(NB), .ACK_WAIT(AW), .ROM_BITS(4)) dut (
        .CLK(CLK), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20),
        .A(A), .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .ACK(ACK), .ACCESS(ACCESS),
        .BASE(BASE), .CONFIGURED(CONFIGURED), .SHUTUP(SHUTUP),
        .CFG_DONE(CFG_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_done();
        for (int i = 0; i < NB; i++) if (!(m_cfg[i] || m_shut[i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_cur();
        for (int i = 0; i < NB; i++) if (!(m_cfg[i] || m_shut[i])) return i;
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_cfg[i] = 1'b0;
            m_shut[i] = 1'b0;
            m_base[i] = 4'h0;
        end
    endtask

    task automatic chk_regs();
        logic [NB-1:0]   ec, es;
        logic [4*NB-1:0] eb;
        for (int i = 0; i < NB; i++) begin
            ec[i] = m_cfg[i];
            es[i] = m_shut[i];
            eb[4*i +: 4] = m_base[i];
        end
        chk("configured", CONFIGURED, ec);
        chk("shutup", SHUTUP, es);
        chk("base", BASE, eb);
        chk("cfg_done", CFG_DONE, m_done());
    endtask

    task automatic chk_reset_vals();
        chk("rst_ack", ACK, 0);
        chk("rst_doe", DOE, 0);
        chk("rst_dout", DOUT, 4'hF);
        chk("rst_cfg", CONFIGURED, 0);
        chk("rst_shut", SHUTUP, 0);
        chk("rst_base", BASE, 0);
        chk("rst_done", CFG_DONE, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        AS20 = 1'b1;
        DS20 = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        m_reset();
        chk_reset_vals();
    endtask

    task automatic run_cycle(input bit rw, input logic [31:0] addr,
                             input logic [3:0] din, input bit abort,
                             input bit rst_hold);
        bit         hit, seen;
        int         cur, lat, n;
        logic [5:0] za;
        za  = addr[6:1];
        hit = (addr[31:16] == 16'h00E8) && !m_done();
        cur = m_cur();
        @(negedge CLK);
        A = addr;
        RW20 = rw;
        DIN = din;
        AS20 = 1'b0;
        DS20 = 1'b0;
        #1 chk("access", ACCESS, !hit);
        if (!hit || abort) begin
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge CLK);
                if (abort && k == 1) begin
                    AS20 = 1'b1;
                    DS20 = 1'b1;
                end
                if (ACK) seen = 1'b1;
            end
            chk("no_ack", seen, 0);
            chk("no_doe", DOE, 0);
        end else begin
            lat = 0;
            while (!ACK && lat < 16) begin
                @(negedge CLK);
                lat++;
            end
            chk("ack_lat", lat, AW + 3);
            chk("doe", DOE, rw);
            if (rw) chk("dout", DOUT, rom_m[cur][za]);
            else if (za == 6'h24) begin
                m_base[cur] = din;
                m_cfg[cur] = 1'b1;
            end else if (za == 6'h26) begin
                m_shut[cur] = 1'b1;
            end
            if (rst_hold) begin
                @(negedge CLK);
                chk("hold_ack", ACK, 1);
                RESET = 1'b1;
                @(negedge CLK);
                chk_reset_vals();
                RESET = 1'b0;
                m_reset();
            end else begin
                AS20 = 1'b1;
                DS20 = 1'b1;
                n = 0;
                while (ACK && n < 10) begin
                    @(negedge CLK);
                    n++;
                end
                chk("ack_drop", n, 3);
                chk("doe_off", DOE, 0);
            end
        end
        AS20 = 1'b1;
        DS20 = 1'b1;
        repeat (3) @(negedge CLK);
        chk_regs();
    endtask

    initial begin
        logic [5:0] zsel [10];
        logic [5:0] z;
        logic [31:0] ad;
        bit          rw;
        zsel = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h13, 6'h24, 6'h24,
                 6'h25, 6'h26, 6'h11};
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 64; j++) rom_m[b][j] = 4'hF;
            rom_m[b][6'h00] = (b == 0) ? 4'hA : 4'hD;
            rom_m[b][6'h01] = (b == 0) ? 4'h2 : 4'h1;
            rom_m[b][6'h03] = 4'hC;
            rom_m[b][6'h04] = 4'h4;
            rom_m[b][6'h08] = 4'hE;
            rom_m[b][6'h09] = 4'hC;
            rom_m[b][6'h0A] = 4'h2;
            rom_m[b][6'h0B] = 4'h7;
            rom_m[b][6'h11] = 4'hE;
            rom_m[b][6'h12] = 4'hB;
            rom_m[b][6'h13] = 4'(5 + b);
        end
        m_reset();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk_reset_vals();
        #1 chk("rst_access", ACCESS, 1);

        run_cycle(1, 32'h00E8_0000, 4'h0, 0, 0);
        run_cycle(1, 32'h00E8_0002, 4'h0, 0, 0);
        run_cycle(1, 32'h00E8_0004, 4'h0, 0, 0);
        run_cycle(0, 32'h00E8_0048, 4'h2, 0, 0);
        run_cycle(1, 32'h00E8_0000, 4'h0, 0, 0);
        run_cycle(0, 32'h00E8_004C, 4'h0, 1, 0);
        run_cycle(1, 32'h00E8_0000, 4'h0, 0, 0);
        run_cycle(0, 32'h00E8_004C, 4'h0, 0, 0);
        run_cycle(1, 32'h00E8_0000, 4'h0, 0, 0);

        do_reset();
        run_cycle(0, 32'h00E8_0048, 4'h5, 0, 0);
        run_cycle(0, 32'h00E8_004C, 4'h0, 0, 1);
        run_cycle(1, 32'h00E8_0000, 4'h0, 0, 0);

        for (int it = 0; it < 80; it++) begin
            if (m_done()) begin
                run_cycle(1, 32'h00E8_0000, 4'h0, 0, 0);
                do_reset();
            end else begin
                z  = zsel[$urandom_range(0, 9)];
                rw = $urandom_range(0, 1) == 1;
                ad = {16'h00E8, 9'($urandom), z, 1'b0};
                if ($urandom_range(0, 9) == 0)
                    ad[31:16] = 16'h00E9 + 16'($urandom_range(0, 100));
                run_cycle(rw, ad, 4'($urandom), $urandom_range(0, 7) == 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
